// File: rtl/cache_way_store_if.sv
// Request/response bundle between the cache controller and the per-set
// way store (valid, dirty and line data arrays).
//
// Signalling: every input is a single-cycle strobe or level sampled at the
// rising clock edge. There is no backpressure and no ready signal. read,
// bit_cmd_valid, mod_wr and dary_write each qualify their own payload in the
// cycle they are high, and the store always accepts them. mod_out is
// combinational from index_q. val_out and dary_out reflect the last captured
// lookup index.
interface cache_way_store_if #(
  parameter int IDX_BITS = 13
);
  logic [IDX_BITS-1:0] index_d;
  logic [IDX_BITS-1:0] index_q;
  logic                read;
  logic [3:0]          way_hit;
  logic [3:0]          bit_cmd;
  logic                bit_cmd_valid;
  logic                mod_wr;
  logic                mod_in;
  logic [3:0]          dary_write;
  logic [255:0]        line_wd;
  logic [31:0]         line_be;
  logic [3:0]          val_out;
  logic [3:0]          mod_out;
  logic [1023:0]       dary_out;

  // Controller side
  modport master (
    output index_d, index_q, read, way_hit, bit_cmd, bit_cmd_valid,
           mod_wr, mod_in, dary_write, line_wd, line_be,
    input  val_out, mod_out, dary_out
  );

  // Storage side
  modport slave (
    input  index_d, index_q, read, way_hit, bit_cmd, bit_cmd_valid,
           mod_wr, mod_in, dary_write, line_wd, line_be,
    output val_out, mod_out, dary_out
  );
endinterface

// File: rtl/cache_way_store.sv
// Per-set storage for a 4-way, 32-byte-line cache: valid bits (command
// driven, flash-clearable), dirty bits, and four byte-writable line arrays.
// Lookups use the request-stage index captured into r_lookup_idx. Updates use
// the compare-stage index_q supplied by the controller.
module cache_way_store #(
  parameter int IDX_BITS = 13
) (
  input logic              clk,
  input logic              reset,
  cache_way_store_if.slave bus
);
  localparam int SETS      = 1 << IDX_BITS;
  localparam int WAYS      = 4;
  localparam int LINE_BITS = 256;
  localparam int LANES     = LINE_BITS / 8;

  // Valid-bit command opcodes (bit_cmd[3:2])
  localparam logic [1:0] CMD_SET_WAY   = 2'b00;
  localparam logic [1:0] CMD_CLR_WAY   = 2'b01;
  localparam logic [1:0] CMD_CLR_SET   = 2'b10;
  localparam logic [1:0] CMD_CLR_ALL   = 2'b11;

  logic [IDX_BITS-1:0]  r_lookup_idx;
  logic [3:0]           r_val_out;
  // Valid bits live in flops rather than RAM so the whole array can be
  // cleared in one cycle.
  logic [3:0]           r_valid [SETS];
  logic [3:0]           r_dirty [SETS];
  logic [LINE_BITS-1:0] r_data  [WAYS][SETS];
  logic [1:0]           w_cmd_op;
  logic [1:0]           w_cmd_way;

  assign w_cmd_op  = bus.bit_cmd[3:2];
  assign w_cmd_way = bus.bit_cmd[1:0];

  // Capture the request-stage index whenever a lookup is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lookup_idx <= '0;
    end else if (bus.read) begin
      r_lookup_idx <= bus.index_d;
    end
  end

  // Valid array. A lookup samples the pre-update bits so a same-edge command
  // shows up only on the following lookup.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_val_out <= '0;
      for (int i = 0; i < SETS; i++) begin
        r_valid[i] <= '0;
      end
    end else begin
      if (bus.read) begin
        r_val_out <= r_valid[bus.index_d];
      end
      if (bus.bit_cmd_valid) begin
        case (w_cmd_op)
          CMD_SET_WAY: r_valid[bus.index_q][w_cmd_way] <= 1'b1;
          CMD_CLR_WAY: r_valid[bus.index_q][w_cmd_way] <= 1'b0;
          CMD_CLR_SET: r_valid[bus.index_q] <= '0;
          CMD_CLR_ALL: begin
            for (int i = 0; i < SETS; i++) begin
              r_valid[i] <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.val_out = r_val_out;

  // Dirty array: write the hit ways at index_q with mod_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SETS; i++) begin
        r_dirty[i] <= '0;
      end
    end else if (bus.mod_wr) begin
      for (int w = 0; w < WAYS; w++) begin
        if (bus.way_hit[w]) begin
          r_dirty[bus.index_q][w] <= bus.mod_in;
        end
      end
    end
  end

  assign bus.mod_out = r_dirty[bus.index_q];

  // Line data arrays: byte-masked writes, not reset and not gated by reset.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < LANES; b++) begin
        if (bus.dary_write[w] && bus.line_be[b]) begin
          r_data[w][bus.index_q][8*b +: 8] <= bus.line_wd[8*b +: 8];
        end
      end
    end
  end

  // Line read for all ways at the captured lookup index.
  always_comb begin
    bus.dary_out = '0;
    for (int w = 0; w < WAYS; w++) begin
      bus.dary_out[LINE_BITS*w +: LINE_BITS] = r_data[w][r_lookup_idx];
    end
  end
endmodule

// File: tb/tb_cache_way_store.sv
// Bench for cache_way_store: directed vectors plus a short constrained burst,
// checked every cycle against an associative-array model of the store and
// pinned by hand-computed literal expectations.
module tb_cache_way_store;
  localparam int IDX_BITS = 13;
  localparam int SETS     = 1 << IDX_BITS;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_way_store_if #(.IDX_BITS(IDX_BITS)) bus ();

  cache_way_store #(.IDX_BITS(IDX_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sparse maps of set contents, missing entries mean 0
  // for valid/dirty and unknown for data.
  logic [3:0]   m_valid [int];
  logic [3:0]   m_dirty [int];
  logic [255:0] m_data  [int];
  int           m_lookup = 0;
  logic [3:0]   m_val    = 4'b0;
  bit           m_live   = 1'b0;

  function automatic logic [3:0] get_valid(input int i);
    return m_valid.exists(i) ? m_valid[i] : 4'b0;
  endfunction

  function automatic logic [3:0] get_dirty(input int i);
    return m_dirty.exists(i) ? m_dirty[i] : 4'b0;
  endfunction

  always @(posedge clk) begin
    int         iq;
    int         key;
    logic [3:0] v;
    logic [255:0] cur;
    iq = int'(bus.index_q);
    if (reset) begin
      m_live   = 1'b1;
      m_lookup = 0;
      m_val    = 4'b0;
      m_valid.delete();
      m_dirty.delete();
    end else begin
      if (bus.read) begin
        m_val    = get_valid(int'(bus.index_d));
        m_lookup = int'(bus.index_d);
      end
      if (bus.bit_cmd_valid) begin
        v = get_valid(iq);
        case (bus.bit_cmd[3:2])
          2'b00: begin v[bus.bit_cmd[1:0]] = 1'b1; m_valid[iq] = v; end
          2'b01: begin v[bus.bit_cmd[1:0]] = 1'b0; m_valid[iq] = v; end
          2'b10: m_valid[iq] = 4'b0;
          default: m_valid.delete();
        endcase
      end
      if (bus.mod_wr) begin
        v = get_dirty(iq);
        for (int w = 0; w < 4; w++) if (bus.way_hit[w]) v[w] = bus.mod_in;
        m_dirty[iq] = v;
      end
    end
    for (int w = 0; w < 4; w++) begin
      if (bus.dary_write[w]) begin
        key = w * SETS + iq;
        cur = m_data.exists(key) ? m_data[key] : 'x;
        for (int b = 0; b < 32; b++) if (bus.line_be[b]) cur[8*b +: 8] = bus.line_wd[8*b +: 8];
        m_data[key] = cur;
      end
    end
  end

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    int key;
    if (m_live) begin
      check4("val_out", bus.val_out, m_val);
      check4("mod_out", bus.mod_out, get_dirty(int'(bus.index_q)));
      for (int w = 0; w < 4; w++) begin
        key = w * SETS + m_lookup;
        if (m_data.exists(key) && !$isunknown(m_data[key]))
          check256($sformatf("dary_out_w%0d", w), bus.dary_out[256*w +: 256], m_data[key]);
      end
    end
  end

  // Driver tasks
  task automatic idle();
    bus.index_d       = '0;
    bus.index_q       = '0;
    bus.read          = 1'b0;
    bus.way_hit       = 4'b0;
    bus.bit_cmd       = 4'b0;
    bus.bit_cmd_valid = 1'b0;
    bus.mod_wr        = 1'b0;
    bus.mod_in        = 1'b0;
    bus.dary_write    = 4'b0;
    bus.line_wd       = '0;
    bus.line_be       = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic write_line(input logic [3:0] ways, input int idx,
                            input logic [255:0] data, input logic [31:0] be);
    bus.index_q    = IDX_BITS'(idx);
    bus.dary_write = ways;
    bus.line_wd    = data;
    bus.line_be    = be;
    step();
    idle();
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] way, input int idx);
    bus.index_q       = IDX_BITS'(idx);
    bus.bit_cmd       = {op, way};
    bus.bit_cmd_valid = 1'b1;
    step();
    idle();
  endtask

  task automatic lookup(input int idx);
    bus.index_d = IDX_BITS'(idx);
    bus.read    = 1'b1;
    step();
    idle();
  endtask

  int           idxs [6] = '{0, 3, 5, 7, 9, 8191};
  logic [255:0] pre  [6][4];
  logic [255:0] d7;
  int           pick [4] = '{3, 5, 7, 9};

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Preload every way at the indices used below (index 3 way 1 is zero)
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 4; w++) begin
        if (idxs[i] == 3 && w == 1) pre[i][w] = '0;
        else pre[i][w] = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
        write_line(4'(1 << w), idxs[i], pre[i][w], 32'hFFFF_FFFF);
      end
    end

    // Reset state lookup at index 5
    bus.read = 1'b1; bus.index_d = 13'd5; bus.index_q = 13'd5;
    step();
    check4("t1_val_after_reset", bus.val_out, 4'b0000);
    check4("t1_mod_after_reset", bus.mod_out, 4'b0000);
    idle();

    // Set way 2 valid, then clear the set
    cmd(2'b00, 2'd2, 5);
    lookup(5);
    check4("t2_set_way2", bus.val_out, 4'b0100);
    cmd(2'b10, 2'd0, 5);
    lookup(5);
    check4("t2_clr_set", bus.val_out, 4'b0000);

    // Dirty writes at index 7
    bus.index_q = 13'd7; bus.mod_wr = 1'b1; bus.mod_in = 1'b1; bus.way_hit = 4'b0001;
    step();
    check4("t3_dirty_set", bus.mod_out, 4'b0001);
    bus.mod_in = 1'b0;
    step();
    check4("t3_dirty_clr", bus.mod_out, 4'b0000);
    bus.mod_in = 1'b1;
    step();
    bus.mod_in = 1'b0; bus.way_hit = 4'b0000;
    step();
    check4("t3_no_hit_noop", bus.mod_out, 4'b0001);
    bus.mod_in = 1'b1; bus.way_hit = 4'b1010;
    step();
    check4("t3_multi_hit", bus.mod_out, 4'b1011);
    idle();

    // Byte-masked write to way 1 index 3
    write_line(4'b0010, 3, {32{8'hA5}}, 32'h0000_000F);
    lookup(3);
    check256("t4_way1_masked", bus.dary_out[511:256], {224'h0, 32'hA5A5_A5A5});
    check256("t4_way0_same", bus.dary_out[255:0],    pre[1][0]);
    check256("t4_way2_same", bus.dary_out[767:512],  pre[1][2]);
    check256("t4_way3_same", bus.dary_out[1023:768], pre[1][3]);

    // Flash clear with valid bits at both index extremes
    for (int w = 0; w < 4; w++) begin
      cmd(2'b00, 2'(w), 0);
      cmd(2'b00, 2'(w), 8191);
    end
    lookup(0);
    check4("t5_idx0_full", bus.val_out, 4'b1111);
    lookup(8191);
    check4("t5_idx8191_full", bus.val_out, 4'b1111);
    cmd(2'b11, 2'd0, 0);
    lookup(0);
    check4("t5_idx0_flash", bus.val_out, 4'b0000);
    lookup(8191);
    check4("t5_idx8191_flash", bus.val_out, 4'b0000);

    // Same-edge lookup and set-valid at index 9
    bus.read = 1'b1; bus.index_d = 13'd9;
    bus.bit_cmd_valid = 1'b1; bus.bit_cmd = 4'b0011; bus.index_q = 13'd9;
    step();
    check4("t6_read_before_write", bus.val_out, 4'b0000);
    idle();
    lookup(9);
    check4("t6_relookup", bus.val_out, 4'b1000);

    // Reset mid-operation: valid/dirty updates suppressed, data write kept
    cmd(2'b00, 2'd0, 5);
    d7 = {8{32'hC0DE_0007}};
    reset = 1'b1;
    bus.bit_cmd_valid = 1'b1; bus.bit_cmd = 4'b0001; bus.index_q = 13'd5;
    bus.mod_wr = 1'b1; bus.mod_in = 1'b1; bus.way_hit = 4'b1111;
    bus.dary_write = 4'b0100; bus.line_wd = d7; bus.line_be = 32'hFFFF_FFFF;
    step();
    idle();
    reset = 1'b0;
    bus.index_q = 13'd7;
    #1;
    check4("t7_dirty_cleared", bus.mod_out, 4'b0000);
    bus.index_q = 13'd5;
    #1;
    check4("t7_dirty_suppressed", bus.mod_out, 4'b0000);
    idle();
    lookup(5);
    check4("t7_valid_cleared", bus.val_out, 4'b0000);
    check256("t7_data_in_reset", bus.dary_out[767:512], d7);

    // Mixed concurrent traffic over a few preloaded sets
    for (int n = 0; n < 40; n++) begin
      bus.read          = 1'($urandom_range(0, 1));
      bus.index_d       = IDX_BITS'(pick[$urandom_range(0, 3)]);
      bus.index_q       = IDX_BITS'(pick[$urandom_range(0, 3)]);
      bus.bit_cmd_valid = 1'($urandom_range(0, 1));
      bus.bit_cmd       = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
      bus.mod_wr        = 1'($urandom_range(0, 1));
      bus.mod_in        = 1'($urandom_range(0, 1));
      bus.way_hit       = 4'($urandom_range(0, 15));
      bus.dary_write    = 4'($urandom_range(0, 15));
      bus.line_wd       = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
      bus.line_be       = $urandom();
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
